veerwolf_board_io: RTL
======================

Name: veerwolf_board_io

Overview:
Parametrised board I/O front-end for VeeRwolf FPGA toplevels, running in the core clock domain between the GPIO block and the board pins. It provides:
- switch synchronisation and debounce, with edge pulses;
- LED output registering with global PWM dimming;
- a glitch-free 2:1 UART TX select that switches source only while both sources are idle.
It replaces the ad-hoc switch/LED flops and the combinational UART TX mux in board toplevels.

Parameters:
SW_WIDTH, 8, number of switch inputs
LED_WIDTH, 8, number of LED outputs
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a switch change (>=1)
PWM_BITS, 4, width of PWM counter and brightness input (>=1)
UART_IDLE_CYCLES, 4340, consecutive cycles both TX lines must be high before switching source (>=1)

Ports:
i_clk  in  1  core clock (single clock domain)
i_rst  in  1  reset, synchronous, active-high
i_sw  in  SW_WIDTH  raw asynchronous switch pins
o_sw  out  SW_WIDTH  synchronised, debounced switch state
o_sw_rise  out  SW_WIDTH  1-cycle pulse per bit on debounced 0->1
o_sw_fall  out  SW_WIDTH  1-cycle pulse per bit on debounced 1->0
i_led  in  LED_WIDTH  LED pattern from GPIO
i_led_dim  in  PWM_BITS  global brightness; 0 = off, all-ones = full on
o_led  out  LED_WIDTH  LED pins
i_tx_sel  in  1  requested TX source (0 = i_tx0, 1 = i_tx1), synchronous to i_clk
i_tx0  in  1  TX source 0 (idle high)
i_tx1  in  1  TX source 1 (idle high)
o_tx  out  1  UART TX pin
o_tx_sel  out  1  currently active TX source

Behaviour:
Reset (i_rst high at a clock edge) clears all state:
- o_sw = 0, o_sw_rise = 0, o_sw_fall = 0;
- o_led = 0, PWM counter = 0;
- o_tx_sel = 0, o_tx = 1, FSM = ACTIVE, idle counter = 0.
Reset asserted mid-debounce or mid-WAIT_IDLE aborts the operation immediately; there is no residual state.

Switch path, per bit:
- 2-flop synchroniser, reset 0.
- Counter of width $clog2(DEBOUNCE_CYCLES+1) increments while the synced value differs from o_sw, and clears when they match.
- When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ:
  - o_sw toggles on the next edge;
  - the counter clears;
  - the matching rise/fall pulse is high in the same cycle that o_sw changes.
- Latency from a stable pin change to the o_sw change is 2 + DEBOUNCE_CYCLES cycles.
- A glitch shorter than DEBOUNCE_CYCLES never changes o_sw.
- Rise and fall pulses are never both high for the same bit.

LED path:
- led_r <= i_led each cycle.
- PWM counter is PWM_BITS wide, free-running, and wraps from all-ones to 0.
- pwm_on = (i_led_dim == all-ones) || (cnt < i_led_dim).
- o_led <= pwm_on ? led_r : 0 (registered).
- Latency from i_led to o_led is 2 cycles.
- Duty cycle is i_led_dim / 2^PWM_BITS, except all-ones = 100%.
- A change of i_led_dim takes effect on the next cycle; there is no period alignment.

UART TX FSM:
- ACTIVE:
  - o_tx <= (o_tx_sel ? i_tx1 : i_tx0).
  - If i_tx_sel != o_tx_sel, go to WAIT_IDLE with the idle counter = 0.
- WAIT_IDLE:
  - o_tx keeps following the current source.
  - If i_tx_sel == o_tx_sel, return to ACTIVE (request withdrawn; no switch).
  - Else if i_tx0 && i_tx1, increment the idle counter; otherwise clear it.
  - When the counter is UART_IDLE_CYCLES-1 and both lines are high: o_tx_sel <= i_tx_sel, go to ACTIVE.
- The new source drives o_tx from the cycle after o_tx_sel changes.
- o_tx never shows a partial character from either source.
- o_tx is registered (1-cycle latency) and resets to 1.
- Only two states exist; an illegal encoding recovers to ACTIVE.

Decomposition:
- Package veerwolf_board_io_pkg holds:
  - the FSM state typedef (ACTIVE, WAIT_IDLE);
  - default-parameter constants DEF_DEBOUNCE_CYCLES and DEF_UART_IDLE_CYCLES.
- Sub-module veerwolf_debounce handles one bit: synchroniser, counter, state, and rise/fall outputs. It is instantiated SW_WIDTH times via generate.
- The LED PWM and TX FSM stay inline.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, PWM_BITS=2, UART_IDLE_CYCLES=3, SW_WIDTH=LED_WIDTH=8.)
- Debounce accept: i_sw 0x00 -> 0x01 held -> o_sw = 0x01 exactly 6 cycles later; o_sw_rise = 0x01 for 1 cycle in that same cycle; o_sw_fall = 0.
- Glitch reject: i_sw[3] high for 3 cycles then low -> o_sw stays 0x00; no pulses.
- Dimming: i_led = 0xA5 with i_led_dim = 1 -> o_led = 0xA5 for 1 of every 4 cycles. i_led_dim = 0 -> o_led = 0 always. i_led_dim = 3 -> o_led = 0xA5 continuously after 2 cycles.
- Safe switch: o_tx_sel = 0, i_tx0 sending a character, i_tx_sel -> 1 -> o_tx_sel stays 0 until both lines are high for 3 consecutive cycles, then o_tx_sel = 1. o_tx follows i_tx0 throughout the character and i_tx1 only afterwards.
- Abort: in WAIT_IDLE, i_tx_sel returns to 0 after 1 idle cycle -> FSM returns to ACTIVE; o_tx_sel remains 0.
- Reset mid-operation: i_rst pulsed during WAIT_IDLE and during a debounce count -> next cycle shows o_tx = 1, o_tx_sel = 0, o_sw = 0, o_led = 0, all pulses 0.

Source files
------------

// File: rtl/veerwolf_board_io_pkg.sv
// Shared definitions for the VeeRwolf board I/O front-end.
//   tx_state_e           : state of the UART TX source-select FSM
//   DEF_DEBOUNCE_CYCLES  : default switch debounce window, in core clock cycles
//   DEF_UART_IDLE_CYCLES : default idle time both TX lines must show before a source swap
package veerwolf_board_io_pkg;

  typedef enum logic {
    ACTIVE    = 1'b0,
    WAIT_IDLE = 1'b1
  } tx_state_e;

  localparam int DEF_DEBOUNCE_CYCLES  = 50000;
  localparam int DEF_UART_IDLE_CYCLES = 4340;

endpackage

// File: rtl/veerwolf_debounce.sv
// Single-bit switch conditioner: 2-flop synchroniser, stability counter and
// debounced state with registered edge pulses.
//   i_clk  : core clock
//   i_rst  : synchronous active-high reset
//   i_sw   : raw asynchronous switch pin
//   o_sw   : debounced switch state
//   o_rise : one-cycle pulse, aligned with o_sw going 0->1
//   o_fall : one-cycle pulse, aligned with o_sw going 1->0
module veerwolf_debounce
  import veerwolf_board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // sync_q[0] is the metastability-catching stage, sync_q[1] is safe to use
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // The counter only runs while the synced pin disagrees with the accepted
  // state; any agreement (a glitch ending) throws the partial count away.
  // The pulses are computed alongside the toggle so they line up with o_sw.
  always_comb begin
    sync_d  = {sync_q[0], i_sw};
    cnt_d   = '0;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ~state_q;
        rise_d  = ~state_q;
        fall_d  = state_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_sw   = state_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/veerwolf_board_io.sv
// Board I/O front-end between the GPIO block and the board pins.
//   i_clk, i_rst          : core clock, synchronous active-high reset
//   i_sw / o_sw           : raw switch pins / debounced switch state
//   o_sw_rise, o_sw_fall  : per-bit one-cycle edge pulses of o_sw
//   i_led, i_led_dim      : LED pattern and global PWM brightness (all-ones = full)
//   o_led                 : registered, dimmed LED pins
//   i_tx_sel              : requested UART TX source (0 = i_tx0, 1 = i_tx1)
//   i_tx0, i_tx1          : UART TX sources, idle high
//   o_tx, o_tx_sel        : registered TX pin and currently active source
module veerwolf_board_io
  import veerwolf_board_io_pkg::*;
#(
  parameter int SW_WIDTH         = 8,
  parameter int LED_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int PWM_BITS         = 4,
  parameter int UART_IDLE_CYCLES = DEF_UART_IDLE_CYCLES
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SW_WIDTH-1:0]  i_sw,
  output logic [SW_WIDTH-1:0]  o_sw,
  output logic [SW_WIDTH-1:0]  o_sw_rise,
  output logic [SW_WIDTH-1:0]  o_sw_fall,
  input  logic [LED_WIDTH-1:0] i_led,
  input  logic [PWM_BITS-1:0]  i_led_dim,
  output logic [LED_WIDTH-1:0] o_led,
  input  logic                 i_tx_sel,
  input  logic                 i_tx0,
  input  logic                 i_tx1,
  output logic                 o_tx,
  output logic                 o_tx_sel
);

  localparam int               IDLE_W    = $clog2(UART_IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(UART_IDLE_CYCLES - 1);

  // One independent debouncer per switch bit
  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    veerwolf_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sw   (i_sw[g]),
      .o_sw   (o_sw[g]),
      .o_rise (o_sw_rise[g]),
      .o_fall (o_sw_fall[g])
    );
  end

  logic [LED_WIDTH-1:0] led_r_q, led_r_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic                 pwm_on;

  // LED pattern is registered once, then gated by the PWM comparator; the
  // all-ones brightness is special-cased so it gives a true 100% duty.
  always_comb begin
    led_r_d   = i_led;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = (i_led_dim == {PWM_BITS{1'b1}}) || (pwm_cnt_q < i_led_dim);
    led_d     = pwm_on ? led_r_q : '0;
  end

  tx_state_e           state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                tx_sel_q, tx_sel_d;
  logic                tx_q, tx_d;

  // The pin always follows the currently active source. A source change is
  // only committed after both lines have been idle long enough that neither
  // can be mid-character, so no partial frame ever reaches the pin.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    tx_sel_d   = tx_sel_q;
    tx_d       = tx_sel_q ? i_tx1 : i_tx0;
    case (state_q)
      ACTIVE: begin
        idle_cnt_d = '0;
        if (i_tx_sel != tx_sel_q) begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (i_tx_sel == tx_sel_q) begin
          state_d    = ACTIVE;
          idle_cnt_d = '0;
        end else if (i_tx0 && i_tx1) begin
          if (idle_cnt_q == IDLE_LAST) begin
            tx_sel_d   = i_tx_sel;
            state_d    = ACTIVE;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ACTIVE;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_r_q    <= '0;
      led_q      <= '0;
      pwm_cnt_q  <= '0;
      state_q    <= ACTIVE;
      idle_cnt_q <= '0;
      tx_sel_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      led_r_q    <= led_r_d;
      led_q      <= led_d;
      pwm_cnt_q  <= pwm_cnt_d;
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      tx_sel_q   <= tx_sel_d;
      tx_q       <= tx_d;
    end
  end

  assign o_led    = led_q;
  assign o_tx     = tx_q;
  assign o_tx_sel = tx_sel_q;

endmodule
